// File: rtl/npc_unit.sv
// Registered PC and next-PC generator: sequential, branch, jump, register-jump,
// stall hold, exception entry/return. NPC_ALIGN_CHECK_EN adds misaligned-jr trapping.
module npc_unit #(
    parameter int             WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_3000,
    parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h0000_4180,
    parameter int             OFFSET_W   = 16,
    parameter int             INDEX_W    = 26
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                branch,
    input  logic [OFFSET_W-1:0] br_offset,
    input  logic                jump,
    input  logic [INDEX_W-1:0]  jump_index,
    input  logic                jr,
    input  logic [WIDTH-1:0]    jr_target,
    input  logic                exc_req,
    input  logic                eret,
    output logic [WIDTH-1:0]    pc,
    output logic [WIDTH-1:0]    pc4,
    output logic [WIDTH-1:0]    epc,
    output logic [WIDTH-1:0]    bad_addr,
    output logic                adel
);

    logic [WIDTH-1:0] br_tgt;
    logic [WIDTH-1:0] j_tgt;
    logic [WIDTH-1:0] npc_flow;
    logic             misalign;
    logic             exc_take;

    assign pc4    = pc + WIDTH'(4);
    assign br_tgt = pc4 + {{(WIDTH-OFFSET_W-2){br_offset[OFFSET_W-1]}}, br_offset, 2'b00};
    assign j_tgt  = {pc4[WIDTH-1:INDEX_W+2], jump_index, 2'b00};

    // Control-flow source when no exception, eret or stall overrides it
    always_comb begin
        npc_flow = pc4;
        if (jr)
            npc_flow = jr_target;
        else if (jump)
            npc_flow = j_tgt;
        else if (branch)
            npc_flow = br_tgt;
    end

`ifdef NPC_ALIGN_CHECK_EN
    assign misalign = jr && !exc_req && !eret && !stall && (jr_target[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            bad_addr <= '0;
            adel     <= 1'b0;
        end else begin
            adel <= misalign;
            if (misalign)
                bad_addr <= jr_target;
        end
    end
`else
    assign misalign = 1'b0;
    assign bad_addr = '0;
    assign adel     = 1'b0;
`endif

    assign exc_take = exc_req || misalign;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc  <= RESET_PC;
            epc <= '0;
        end else if (exc_take) begin
            pc  <= EXC_VECTOR;
            epc <= pc;
        end else if (eret) begin
            pc <= epc;
        end else if (!stall) begin
            pc <= npc_flow;
        end
    end

endmodule

// File: tb/tb_npc_unit.sv
// Directed bench for npc_unit: a priority-rule model checked every cycle, plus literal PC expectations.
module tb_npc_unit;

    logic        clk = 1'b0;
    logic        reset, stall, branch, jump, jr, exc_req, eret;
    logic [15:0] br_offset;
    logic [25:0] jump_index;
    logic [31:0] jr_target;
    logic [31:0] pc, pc4, epc, bad_addr;
    logic        adel;

    int n_chk = 0;
    int n_fail = 0;

    npc_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .branch(branch), .br_offset(br_offset),
        .jump(jump), .jump_index(jump_index), .jr(jr), .jr_target(jr_target),
        .exc_req(exc_req), .eret(eret), .pc(pc), .pc4(pc4), .epc(epc),
        .bad_addr(bad_addr), .adel(adel)
    );

    always #5 clk = ~clk;

    // Reference model: next state from the priority rules, using its own state only
    logic [31:0] m_pc, m_epc, m_bad;
    logic        m_adel;
    logic        m_valid = 1'b0;
`ifdef NPC_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    always @(posedge clk) begin
        logic [31:0] seq, tgt;
        logic        mis;
        seq = m_pc + 32'd4;
        mis = ALIGN && jr && !exc_req && !eret && !stall && (jr_target % 4 != 0);
        if (reset) begin
            m_pc = 32'h3000; m_epc = 0; m_bad = 0; m_adel = 0; m_valid = 1'b1;
        end else begin
            m_adel = mis;
            if (exc_req || mis) begin
                if (mis) m_bad = jr_target;
                m_epc = m_pc;
                m_pc  = 32'h4180;
            end else if (eret) begin
                m_pc = m_epc;
            end else if (!stall) begin
                if (jr)          tgt = jr_target;
                else if (jump)   tgt = (seq & 32'hF000_0000) | (32'(jump_index) * 4);
                else if (branch) tgt = seq + 32'($signed(br_offset) * 4);
                else             tgt = seq;
                m_pc = tgt;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        if (m_valid) begin
            chk("pc", pc, m_pc);
            chk("pc4", pc4, m_pc + 32'd4);
            chk("epc", epc, m_epc);
            chk("bad_addr", bad_addr, m_bad);
            chk("adel", {31'd0, adel}, {31'd0, m_adel});
        end
    end

    task automatic idle();
        reset = 0; stall = 0; branch = 0; jump = 0; jr = 0; exc_req = 0; eret = 0;
        br_offset = 0; jump_index = 0; jr_target = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
        idle();
    endtask

    task automatic go_jr(input logic [31:0] t);
        jr = 1; jr_target = t; cyc();
    endtask

    initial begin
        idle();
        reset = 1;
        cyc();
        chk("reset_pc", pc, 32'h3000);
        chk("reset_pc4", pc4, 32'h3004);
        chk("reset_epc", epc, 32'h0);
        chk("reset_adel", {31'd0, adel}, 32'd0);
        cyc(); chk("idle1", pc, 32'h3004);
        cyc(); chk("idle2", pc, 32'h3008);
        cyc(); chk("idle3", pc, 32'h300C);
        chk("idle3_pc4", pc4, 32'h3010);

        go_jr(32'h3008);
        branch = 1; br_offset = 16'hFFFF; cyc(); chk("br_neg1", pc, 32'h3008);
        branch = 1; br_offset = 16'h0003; cyc(); chk("br_pos3", pc, 32'h3018);

        go_jr(32'h3000);
        jump = 1; jump_index = 26'h0000C10; cyc(); chk("jump", pc, 32'h3040);
        jr = 1; jump = 1; jr_target = 32'h3100; jump_index = 26'h1; cyc(); chk("jr_over_jump", pc, 32'h3100);
        jump = 1; branch = 1; br_offset = 16'h0010; jump_index = 26'h0000C20; cyc();
        chk("jump_over_branch", pc, 32'h3080);

        go_jr(32'h3010);
        stall = 1; branch = 1; br_offset = 16'h0004; cyc(); chk("stall_hold", pc, 32'h3010);
        stall = 1; exc_req = 1; cyc();
        chk("stall_exc_pc", pc, 32'h4180);
        chk("stall_exc_epc", epc, 32'h3010);
        cyc(); chk("handler_seq", pc, 32'h4184);
        stall = 1; eret = 1; cyc(); chk("eret_over_stall", pc, 32'h3010);
        chk("eret_epc_kept", epc, 32'h3010);
        cyc(); chk("after_eret", pc, 32'h3014);
        exc_req = 1; eret = 1; cyc();
        chk("exc_eret_pc", pc, 32'h4180);
        chk("exc_eret_epc", epc, 32'h3014);

        go_jr(32'hFFFF_FFFC);
        chk("pc4_wrap", pc4, 32'h0);
        cyc(); chk("pc_wrap", pc, 32'h0);
        branch = 1; br_offset = 16'h8000; cyc(); chk("br_underflow", pc, 32'hFFFE_0004);
        go_jr(32'hFFFF_FFF0);
        branch = 1; br_offset = 16'h0008; cyc(); chk("br_overflow", pc, 32'h0000_0014);

        reset = 1; exc_req = 1; jr = 1; jr_target = 32'h5000; cyc();
        chk("reset_exc_pc", pc, 32'h3000);
        chk("reset_exc_epc", epc, 32'h0);

        go_jr(32'h3020);
        go_jr(32'h3102);
`ifdef NPC_ALIGN_CHECK_EN
        chk("mis_pc", pc, 32'h4180);
        chk("mis_epc", epc, 32'h3020);
        chk("mis_bad", bad_addr, 32'h3102);
        chk("mis_adel", {31'd0, adel}, 32'd1);
        cyc();
        chk("mis_adel_drop", {31'd0, adel}, 32'd0);
        chk("mis_bad_kept", bad_addr, 32'h3102);
        stall = 1; jr = 1; jr_target = 32'h3202; cyc();
        chk("mis_stalled", pc, 32'h4184);
`else
        chk("nomis_pc", pc, 32'h3102);
        chk("nomis_adel", {31'd0, adel}, 32'd0);
        chk("nomis_bad", bad_addr, 32'h0);
        cyc();
        chk("nomis_seq", pc, 32'h3106);
`endif
        cyc();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/npc_unit.md
# npc_unit

Registered program-counter and next-PC generator for the MIPS datapath. It replaces the standalone branch-target adder. It holds the PC and computes the sequential, branch, jump and register-jump targets. It adds stall hold, exception entry to a fixed vector, and exception return through an EPC register. It sits at the head of the fetch stage; `pc` drives instruction memory and `pc4` feeds the link path.

## Interface
- `WIDTH`, 32, address width; must be greater than `INDEX_W`+2.
- `RESET_PC`, 32'h0000_3000, PC value loaded by reset.
- `EXC_VECTOR`, 32'h0000_4180, exception handler entry address.
- `OFFSET_W`, 16, branch offset width (signed, word units).
- `INDEX_W`, 26, jump index width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold PC (hazard stall).
- `branch`  in  1  branch taken this cycle.
- `br_offset`  in  `OFFSET_W`  signed word offset.
- `jump`  in  1  j/jal this cycle.
- `jump_index`  in  `INDEX_W`  jump index field.
- `jr`  in  1  jr/jalr this cycle.
- `jr_target`  in  `WIDTH`  register jump target.
- `exc_req`  in  1  take exception this cycle.
- `eret`  in  1  return from exception.
- `pc`  out  `WIDTH`  current PC (registered).
- `pc4`  out  `WIDTH`  `pc`+4 (combinational).
- `epc`  out  `WIDTH`  saved exception PC (registered).
- `bad_addr`  out  `WIDTH`  last misaligned jr target (registered).
- `adel`  out  1  misaligned-fetch exception taken last edge (registered pulse).

## Operation
- Targets are computed from the current `pc`, all arithmetic modulo 2^`WIDTH`:
  - `pc4` = `pc` + 4.
  - Branch target = `pc4` + (sign-extend(`br_offset`) << 2).
  - Jump target = {`pc4`[`WIDTH`-1:`INDEX_W`+2], `jump_index`, 2'b00}.
  - Register-jump target = `jr_target`.
- Next-PC priority, highest first; exactly one source applies per edge:
  1. `reset`: `pc`←`RESET_PC`, `epc`←0, `bad_addr`←0, `adel`←0.
  2. `exc_req`, or an internal misalign when the macro is defined: `pc`←`EXC_VECTOR`, `epc`←`pc`. This applies even while `stall` is high.
  3. `eret`: `pc`←`epc`; `epc` is unchanged.
  4. `stall`: `pc` holds; `jr`, `jump` and `branch` are ignored.
  5. `jr`: `pc`←`jr_target`.
  6. `jump`: `pc`←jump target.
  7. `branch`: `pc`←branch target.
  8. Otherwise: `pc`←`pc4`.
- Simultaneous `exc_req` and `eret`: the exception wins and `epc`←current `pc`.
- `eret` with `stall` high: `eret` wins.
- Multiple control-flow inputs high: resolved by the priority order above; no error is flagged.
- Reset mid-operation discards any pending redirect; the first fetch after reset is `RESET_PC`.
- Wrap-around:
  - `pc`=32'hFFFF_FFFC with no redirect → `pc`=0.
  - A branch target overflowing either way wraps silently.
- `epc` changes only on exception entry or reset. `bad_addr` changes only on a misaligned-fetch exception or reset.

## Timing
- `pc`, `epc`, `bad_addr` and `adel` update only on the rising `clk` edge.
- All control inputs are sampled at that edge; a redirect is visible on `pc` one cycle after its request.
- `pc4` and the target computations are combinational from `pc`, with zero added latency.
- `adel` is high for exactly the one cycle following the edge on which the misaligned exception was taken.
- Outputs after reset: `pc`=`RESET_PC`, `pc4`=`RESET_PC`+4, `epc`=0, `bad_addr`=0, `adel`=0.

## Configuration
- `NPC_ALIGN_CHECK_EN` defined:
  - Condition: `jr` is the selected source (no reset, `exc_req`, `eret` or `stall`) and `jr_target`[1:0]≠0.
  - Effect: this is treated as an exception. `pc`←`EXC_VECTOR`, `epc`←`pc`, `bad_addr`←`jr_target`, `adel`←1 for one cycle.
- Not defined:
  - `jr_target` is loaded unchanged, including its low bits.
  - `bad_addr` and `adel` are constant 0.
  - No alignment logic is instantiated.

## Test plan
- Reset then 3 idle cycles → `pc` = 0x3000, 0x3004, 0x3008, 0x300C; `pc4` tracks `pc`+4; `epc`=0.
- `pc`=0x3008:
  - `branch`, `br_offset`=16'hFFFF → next `pc`=0x3008.
  - `br_offset`=16'h0003 → next `pc`=0x3018.
- `pc`=0x3000, `jump`, `jump_index`=26'h0000C10 → 0x3040. Then `jr`+`jump` both high, `jr_target`=0x3100 → 0x3100 (`jr` wins).
- Stall and exception handling:
  - `stall`+`branch` at `pc`=0x3010 → `pc` holds 0x3010.
  - `stall`+`exc_req` → `pc`=0x4180, `epc`=0x3010.
  - Then `eret` → `pc`=0x3010.
  - Separately, `exc_req`+`eret` together → vector taken, `epc`=current `pc`.
- Wrap and reset:
  - Force `pc`=0xFFFF_FFFC, idle → `pc`=0.
  - Assert `reset` in the same cycle as `exc_req` → `pc`=0x3000, `epc`=0.
- Alignment check:
  - With the macro, `jr`, `jr_target`=0x3102 at `pc`=0x3020 → `pc`=0x4180, `epc`=0x3020, `bad_addr`=0x3102, `adel`=1 for one cycle.
  - Without the macro → `pc`=0x3102, `adel`=0.
